// File: rtl/vga_sync.sv
// vga_sync: 640x480 VGA timing generator with pixel-rate divider, sync generation, frame tick and output blanking.
// Latency: pixel_x/pixel_y/hsync/vsync/refresh_tick/frame_count registered; rgb_out is rgb_in delayed 1 clk; video_on combinational.
// Backpressure: none; free-running timing source, consumers must keep up with p_tick and refresh_tick.
//
// Ports:
//   clk          - system clock, all state on rising edge
//   reset        - synchronous active-high reset
//   rgb_in       - 12-bit composed pixel colour
//   pixel_x      - horizontal count 0..H_TOTAL-1
//   pixel_y      - vertical count 0..V_TOTAL-1
//   video_on     - high inside the visible area
//   p_tick       - one-clk strobe per pixel period
//   hsync/vsync  - active-low sync pulses, aligned with pixel_x/pixel_y
//   refresh_tick - one-clk pulse at the start of vertical blanking
//   frame_count  - frames completed, wraps at 255
//   rgb_out      - registered, blanked colour to the DAC

module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        p_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        refresh_tick,
    output logic [7:0]  frame_count,
    output logic [11:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    // All counter comparisons are done against 10-bit constants so the
    // compares stay unsigned and width-matched.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] V_VIS_LAST = 10'(V_DISPLAY - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_end;
    logic             v_end;
    logic             hsync_next;
    logic             vsync_next;
    logic             frame_edge;

    // Pixel strobe straight off the divider: high for exactly one clk per
    // pixel period, and low out of reset because div_cnt restarts at 0.
    assign p_tick = (div_cnt == DIV_LAST);

    assign h_end = (h_count == H_LAST);
    assign v_end = (v_count == V_LAST);

    // Next-state counters. Sync outputs are registered from these so the
    // sync level always belongs to the pixel_x/pixel_y being shown.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (p_tick) begin
            if (h_end) begin
                h_next = 10'd0;
                v_next = v_end ? 10'd0 : v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
            end
        end
    end

    assign hsync_next = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
    assign vsync_next = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));

    // The edge that steps from the last visible line into the first
    // blanking line. It is gated by p_tick, so the registered pulse lasts
    // one clk whatever CLK_DIV is.
    assign frame_edge = p_tick && h_end && (v_count == V_VIS_LAST);

    assign video_on = (h_count < H_VIS) && (v_count < V_VIS);

    assign pixel_x = h_count;
    assign pixel_y = v_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            h_count      <= 10'd0;
            v_count      <= 10'd0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            refresh_tick <= 1'b0;
            frame_count  <= 8'd0;
            rgb_out      <= 12'h000;
        end else begin
            div_cnt      <= p_tick ? '0 : div_cnt + DIV_W'(1);
            h_count      <= h_next;
            v_count      <= v_next;
            hsync        <= hsync_next;
            vsync        <= vsync_next;
            refresh_tick <= frame_edge;
            frame_count  <= frame_count + {7'd0, frame_edge};
            // Blanking uses video_on from before the edge, so colour and
            // blanking move together with a single clk of latency.
            rgb_out      <= video_on ? rgb_in : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

    // Shrunken raster so several frames fit in a short run; CLK_DIV of 3
    // exercises a divider that is not a power of two.
    localparam int D   = 3;
    localparam int HD  = 16;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 2;
    localparam int VD  = 6;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int HT  = HD + HF + HS + HB;
    localparam int VT  = VD + VF + VS + VB;
    localparam int FR  = HT * VT;
    localparam int HS0 = HD + HF;
    localparam int HS1 = HD + HF + HS - 1;
    localparam int VS0 = VD + VF;
    localparam int VS1 = VD + VF + VS - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] rgb_in;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        p_tick;
    logic        hsync;
    logic        vsync;
    logic        refresh_tick;
    logic [7:0]  frame_count;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    vga_sync #(
        .CLK_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
        .refresh_tick(refresh_tick), .frame_count(frame_count), .rgb_out(rgb_out)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: n is the number of clk edges since reset release.
    // Everything else follows from plain arithmetic on n.
    int          n = 0;
    logic [11:0] exp_rgb = 12'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    function automatic logic model_video_on(input int cyc);
        int pos;
        pos = (cyc / D) % FR;
        return ((pos % HT) < HD) && ((pos / HT) < VD);
    endfunction

    task automatic check_all();
        int   p, pos, x, y, fc;
        logic e_pt, e_hs, e_vs, e_vo, e_rt;
        p    = n / D;
        pos  = p % FR;
        x    = pos % HT;
        y    = pos / HT;
        e_pt = (n % D) == (D - 1);
        e_hs = !((x >= HS0) && (x <= HS1));
        e_vs = !((y >= VS0) && (y <= VS1));
        e_vo = (x < HD) && (y < VD);
        e_rt = (n > 0) && ((n % D) == 0) && (pos == VD * HT);
        fc   = (p >= VD * HT) ? (((p - VD * HT) / FR) + 1) % 256 : 0;
        chk("pixel_x",      32'(pixel_x),      32'(x));
        chk("pixel_y",      32'(pixel_y),      32'(y));
        chk("p_tick",       32'(p_tick),       32'(e_pt));
        chk("hsync",        32'(hsync),        32'(e_hs));
        chk("vsync",        32'(vsync),        32'(e_vs));
        chk("video_on",     32'(video_on),     32'(e_vo));
        chk("refresh_tick", 32'(refresh_tick), 32'(e_rt));
        chk("frame_count",  32'(frame_count),  32'(fc));
        chk("rgb_out",      32'(rgb_out),      32'(exp_rgb));
    endtask

    // One clk: drive inputs, take the edge, advance the model, check #1 later.
    task automatic step(input logic rst, input logic [11:0] rgb);
        logic vo_before;
        reset     = rst;
        rgb_in    = rgb;
        vo_before = model_video_on(n);
        @(posedge clk);
        if (rst) begin
            n       = 0;
            exp_rgb = 12'h000;
        end else begin
            exp_rgb = vo_before ? rgb : 12'h000;
            n       = n + 1;
        end
        #1;
        check_all();
    endtask

    initial begin
        int   pulses;
        int   last_pulse;
        int   first_pt;
        int   hlow;
        int   vlow;
        logic found;

        reset  = 1'b1;
        rgb_in = 12'h000;

        // Reset state.
        repeat (3) step(1'b1, 12'($urandom));

        // Two frames from release: divider phase, first pixel step, sync
        // widths and the first two refresh pulses.
        pulses     = 0;
        last_pulse = 0;
        first_pt   = -1;
        hlow       = 0;
        vlow       = 0;
        for (int i = 0; i < VD * HT * D + FR * D + 10; i++) begin
            step(1'b0, 12'($urandom));
            if (p_tick === 1'b1 && first_pt < 0) begin
                first_pt = n;
                chk("first_p_tick_cycle", 32'(first_pt), 32'(D - 1));
            end
            if (n == D)
                chk("pixel_x_after_first_tick", 32'(pixel_x), 32'd1);
            if (n < HT * D && hsync === 1'b0)
                hlow++;
            if (n < FR * D && vsync === 1'b0)
                vlow++;
            if (refresh_tick === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    chk("first_refresh_clk", 32'(n), 32'(VD * HT * D));
                    chk("first_refresh_x", 32'(pixel_x), 32'd0);
                    chk("first_refresh_y", 32'(pixel_y), 32'(VD));
                    chk("first_refresh_fc", 32'(frame_count), 32'd1);
                end else if (pulses == 2) begin
                    chk("refresh_period", 32'(n - last_pulse), 32'(FR * D));
                    chk("second_refresh_fc", 32'(frame_count), 32'd2);
                end
                last_pulse = n;
            end
        end
        chk("refresh_pulse_count", 32'(pulses), 32'd2);
        chk("hsync_low_clks", 32'(hlow), 32'(HS * D));
        chk("vsync_low_clks", 32'(vlow), 32'(VS * HT * D));

        // Constant colour across two lines: blanking edges show in rgb_out.
        for (int i = 0; i < 2 * HT * D; i++)
            step(1'b0, 12'hABC);

        // Reset inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < FR * D + 10 && !found; i++) begin
            step(1'b0, 12'($urandom));
            if (pixel_x == 10'(HS0 + 1) && pixel_y == 10'(VS0))
                found = 1'b1;
        end
        chk("reached_reset_point", 32'(found), 32'd1);
        chk("hsync_low_before_reset", 32'(hsync), 32'd0);
        step(1'b1, 12'hFFF);
        chk("rst_pixel_x", 32'(pixel_x), 32'd0);
        chk("rst_pixel_y", 32'(pixel_y), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb_out", 32'(rgb_out), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);

        // Random colour with occasional random resets, for a couple of frames.
        for (int i = 0; i < 2 * FR * D; i++)
            step(($urandom_range(0, 299) == 0), 12'($urandom));

        // Clean run across a refresh point after the random section.
        for (int i = 0; i < FR * D; i++)
            step(1'b0, 12'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
